instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of the instruction ROM: owns the program counter, drives the
//  ROM word address, captures the combinational ROM read the same cycle and buffers {pc, instr}
//  pairs in a small prefetch FIFO. Decode drains the FIFO over a valid/ready handshake.
//  Branch/jump redirects from execute flush the FIFO and reload the PC.
// PARAMETERS
//  ADDRESS_WIDTH  32            PC / ROM address width (bits)
//  DATA_WIDTH     32            instruction width (bits)
//  FIFO_DEPTH     4             prefetch entries; power of two, >= 2
//  RESET_PC       32'h0000_0000 byte address fetched first after reset
// PORTS
//  clk           in   1              rising-edge clock
//  rst_n         in   1              asynchronous active-low reset
//  rom_addr      out  ADDRESS_WIDTH  word address to ROM = {2'b00, pc[AW-1:2]}
//  rom_instr     in   DATA_WIDTH     combinational ROM data for rom_addr
//  redirect      in   1              execute taken branch/jump this cycle
//  redirect_pc   in   ADDRESS_WIDTH  redirect target byte address; bits [1:0] forced to 0
//  out_valid     out  1              head entry available to decode
//  out_ready     in   1              decode accepts head entry
//  out_pc        out  ADDRESS_WIDTH  byte address of head instruction
//  out_instr     out  DATA_WIDTH     head instruction
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc=RESET_PC, FIFO empty (count=0, ptrs=0); out_valid=0,
//    out_pc=0, out_instr=NOP (32'h0000_0013), rom_addr=RESET_PC>>2. Mid-operation reset drops all
//    buffered entries immediately, no handshake completes.
//  - pop  = out_valid & out_ready.
//  - push = !redirect & ((count < FIFO_DEPTH) | pop); pushes {pc, rom_instr}, pc <= pc + 4.
//    Full FIFO with simultaneous pop: push and pop both happen, count unchanged.
//  - PC arithmetic modulo 2**ADDRESS_WIDTH: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.
//  - Latency: ROM sampled in the cycle pc is presented; entry is visible at out_* the cycle
//    after the push edge. The first out_valid=1 follows the first rising edge after rst_n
//    deasserts.
//  - out_valid = (count != 0) & !redirect. Empty FIFO: out_pc=0, out_instr=NOP. Otherwise
//    out_* show the head entry, held stable while out_valid & !out_ready.
//  - redirect=1: out_valid forced 0 combinationally (no pop that cycle). On the edge: FIFO
//    cleared, pc <= {redirect_pc[AW-1:2],2'b00}, no push. Next cycle fetches from target.
//    Back-to-back redirects: the last one wins. Redirect while empty or full behaves the same.
//  - Throughput: 1 instr/cycle sustained with out_ready=1. With out_ready=0, fetch stops once
//    count==FIFO_DEPTH; pc holds at the next unfetched address.
//  - count width $clog2(FIFO_DEPTH)+1; ptrs $clog2(FIFO_DEPTH) bits, wrap naturally.
//  - No state machine beyond FIFO occupancy; all state on the single clk domain.
// STRUCTURE
//  - fetch_pkg: addr_t, instr_t, typedef struct packed {addr_t pc; instr_t instr;}
//    fetch_entry_t, localparam instr_t NOP_INSTR = 32'h0000_0013.
//  - Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t (push/pop/flush, count, full,
//    empty, head). The top level holds the PC register, push/pop logic and out_* muxing.
// TESTING
//  1. Reset release, RESET_PC=0, ROM[i]=i, out_ready=1 -> out_pc 0,4,8,12 with instr 0,1,2,3
//     on consecutive cycles; out_valid=0 during reset.
//  2. out_ready=0 for 10 cycles (DEPTH=4) -> count saturates at 4, rom_addr holds 4 (pc=16),
//     out_pc holds 0. Release -> 0,4,8,12,16 with no gap or duplicate.
//  3. redirect=1, redirect_pc=32'h40 while full -> out_valid=0 that cycle; next cycle FIFO
//     empty, rom_addr=16; following cycle out_pc=0x40, out_instr=ROM[16].
//  4. redirect_pc=32'h43 -> fetch resumes at 0x40; two consecutive redirects (0x80 then 0x100)
//     -> first output is out_pc=0x100.
//  5. RESET_PC=32'hFFFF_FFF8, out_ready=1 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
//  6. rst_n pulled low mid-stream with 3 buffered entries -> out_valid=0 and out_instr=NOP
//     immediately (async); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: address/instruction words and
// the {pc, instr} record buffered between fetch and decode.
package fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    addr_t  pc;
    instr_t instr;
  } fetch_entry_t;

  // addi x0, x0, 0 -- shown to decode whenever nothing is buffered.
  localparam instr_t NOP_INSTR = 32'h0000_0013;

  // Byte address of the instruction following the one at pc; wraps modulo 2**ADDR_W.
  function automatic addr_t next_pc(input addr_t pc);
    return pc + ADDR_W'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO of fetch entries with push/pop/flush.
// Control state resets asynchronously; the storage array is data only and is not reset.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  input  logic                       flush,
  output entry_t                     head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push;
  logic            do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses the combinational instruction ROM and
// buffers {pc, instr} pairs for decode; execute redirects flush and reload the PC.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       FIFO_DEPTH    = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_instr,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0]    out_instr
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]    instr;
  } entry_t;

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  entry_t                   push_entry;
  entry_t                   head;
  logic [CW-1:0]            fifo_count;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;

  assign rom_addr = {2'b00, pc_q[ADDRESS_WIDTH-1:2]};

  always_comb begin
    out_valid        = (fifo_count != '0) & ~redirect;
    pop              = out_valid & out_ready;
    push             = ~redirect & (~fifo_full | pop);
    push_entry.pc    = pc_q;
    push_entry.instr = rom_instr;
    pc_d             = pc_q;
    // The redirect target is forced word aligned; a redirect edge never fetches.
    if (redirect)  pc_d = redirect_pc & ~ADDRESS_WIDTH'(3);
    else if (push) pc_d = pc_q + ADDRESS_WIDTH'(4);
  end

  always_comb begin
    out_pc    = '0;
    out_instr = DATA_WIDTH'(NOP_INSTR);
    if (!fifo_empty) begin
      out_pc    = head.pc;
      out_instr = head.instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit with an identity ROM (ROM[i] = i).
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rom_addr, rom_instr;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_instr;

  logic [31:0] rom_addr_hi, rom_instr_hi;
  logic        out_valid_hi;
  logic [31:0] out_pc_hi, out_instr_hi;
  logic        redirect_hi = 1'b0;
  logic [31:0] redirect_pc_hi = '0;
  logic        out_ready_hi = 1'b1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rom_instr    = rom_addr;
  assign rom_instr_hi = rom_addr_hi;

  instr_fetch_unit #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .FIFO_DEPTH    (4),
    .RESET_PC      (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_addr    (rom_addr),
    .rom_instr   (rom_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr)
  );

  instr_fetch_unit #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .FIFO_DEPTH    (4),
    .RESET_PC      (32'hFFFF_FFF8)
  ) dut_hi (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_addr    (rom_addr_hi),
    .rom_instr   (rom_instr_hi),
    .redirect    (redirect_hi),
    .redirect_pc (redirect_pc_hi),
    .out_valid   (out_valid_hi),
    .out_ready   (out_ready_hi),
    .out_pc      (out_pc_hi),
    .out_instr   (out_instr_hi)
  );

  typedef struct {
    logic        do_rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ei;
    logic [31:0] erom;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic do_rst, input logic redir, input logic [31:0] rpc,
                             input logic rdy, input logic ev, input logic [31:0] epc,
                             input logic [31:0] ei, input logic [31:0] erom);
    vec_t r;
    r.do_rst = do_rst; r.redir = redir; r.rpc = rpc; r.rdy = rdy;
    r.ev = ev; r.epc = epc; r.ei = ei; r.erom = erom;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Assert reset away from a clock edge, check the async state, release just after a posedge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    redirect  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk({tag, " rst out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, " rst out_pc"}, out_pc, 32'd0);
    chk({tag, " rst out_instr"}, out_instr, NOP);
    chk({tag, " rst rom_addr"}, rom_addr, 32'd0);
    chk({tag, " rst hi rom_addr"}, rom_addr_hi, 32'h3FFF_FFFE);
    chk({tag, " rst hi out_valid"}, {31'b0, out_valid_hi}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic apply_row(input string tag, input vec_t r);
    if (r.do_rst) do_reset(tag);
    @(negedge clk);
    redirect    = r.redir;
    redirect_pc = r.rpc;
    out_ready   = r.rdy;
    #1;
    chk({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, r.ev});
    chk({tag, " out_pc"}, out_pc, r.epc);
    chk({tag, " out_instr"}, out_instr, r.ei);
    chk({tag, " rom_addr"}, rom_addr, r.erom);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] hi_pc [4];
    logic [31:0] hi_in [4];
    logic [31:0] hi_rom[4];
    logic        hi_v  [4];

    // Reset release and streaming at one instruction per cycle.
    tbl.push_back(v(1, 0, 0, 1, 0, 0,  NOP, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 0,  0,   1));
    tbl.push_back(v(0, 0, 0, 1, 1, 4,  1,   2));
    tbl.push_back(v(0, 0, 0, 1, 1, 8,  2,   3));
    tbl.push_back(v(0, 0, 0, 1, 1, 12, 3,   4));
    // Backpressure fills the FIFO; pc stalls at 16; release drains without gap.
    tbl.push_back(v(1, 0, 0, 0, 0, 0, NOP, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0,   1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0,   2));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0,   3));
    for (int i = 0; i < 7; i++) tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 4));
    tbl.push_back(v(0, 0, 0, 1, 1, 0,  0, 4));
    tbl.push_back(v(0, 0, 0, 1, 1, 4,  1, 5));
    tbl.push_back(v(0, 0, 0, 1, 1, 8,  2, 6));
    tbl.push_back(v(0, 0, 0, 1, 1, 12, 3, 7));
    tbl.push_back(v(0, 0, 0, 1, 1, 16, 4, 8));
    // Redirect while full, unaligned target, back-to-back redirects.
    tbl.push_back(v(1, 0, 0,         0, 0, 0,      NOP,   0));
    tbl.push_back(v(0, 0, 0,         0, 1, 0,      0,     1));
    tbl.push_back(v(0, 0, 0,         0, 1, 0,      0,     2));
    tbl.push_back(v(0, 0, 0,         0, 1, 0,      0,     3));
    tbl.push_back(v(0, 0, 0,         0, 1, 0,      0,     4));
    tbl.push_back(v(0, 1, 32'h40,    1, 0, 0,      0,     4));
    tbl.push_back(v(0, 0, 0,         1, 0, 0,      NOP,   16));
    tbl.push_back(v(0, 0, 0,         1, 1, 32'h40, 16,    17));
    tbl.push_back(v(0, 1, 32'h43,    1, 0, 32'h44, 17,    18));
    tbl.push_back(v(0, 0, 0,         1, 0, 0,      NOP,   16));
    tbl.push_back(v(0, 0, 0,         1, 1, 32'h40, 16,    17));
    tbl.push_back(v(0, 1, 32'h80,    1, 0, 32'h44, 17,    18));
    tbl.push_back(v(0, 1, 32'h100,   1, 0, 0,      NOP,   32'h20));
    tbl.push_back(v(0, 0, 0,         1, 0, 0,      NOP,   32'h40));
    tbl.push_back(v(0, 0, 0,         1, 1, 32'h100, 32'h40, 32'h41));

    foreach (tbl[i]) apply_row($sformatf("row%0d", i), tbl[i]);

    // PC wraparound on the instance reset at 0xFFFF_FFF8.
    do_reset("wrap");
    hi_v[0] = 1'b0; hi_pc[0] = 32'h0;         hi_in[0] = NOP;           hi_rom[0] = 32'h3FFF_FFFE;
    hi_v[1] = 1'b1; hi_pc[1] = 32'hFFFF_FFF8; hi_in[1] = 32'h3FFF_FFFE; hi_rom[1] = 32'h3FFF_FFFF;
    hi_v[2] = 1'b1; hi_pc[2] = 32'hFFFF_FFFC; hi_in[2] = 32'h3FFF_FFFF; hi_rom[2] = 32'h0;
    hi_v[3] = 1'b1; hi_pc[3] = 32'h0;         hi_in[3] = 32'h0;         hi_rom[3] = 32'h1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("wrap%0d out_valid", k), {31'b0, out_valid_hi}, {31'b0, hi_v[k]});
      chk($sformatf("wrap%0d out_pc", k), out_pc_hi, hi_pc[k]);
      chk($sformatf("wrap%0d out_instr", k), out_instr_hi, hi_in[k]);
      chk($sformatf("wrap%0d rom_addr", k), rom_addr_hi, hi_rom[k]);
    end

    // Mid-stream async reset with three buffered entries.
    do_reset("mid");
    apply_row("mid0", v(0, 0, 0, 0, 0, 0, NOP, 0));
    apply_row("mid1", v(0, 0, 0, 0, 1, 0, 0,   1));
    apply_row("mid2", v(0, 0, 0, 0, 1, 0, 0,   2));
    @(negedge clk);
    #1;
    chk("mid3 out_valid", {31'b0, out_valid}, 32'd1);
    chk("mid3 rom_addr", rom_addr, 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst out_instr", out_instr, NOP);
    chk("midrst out_pc", out_pc, 32'd0);
    chk("midrst rom_addr", rom_addr, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    apply_row("after0", v(0, 0, 0, 1, 0, 0, NOP, 0));
    apply_row("after1", v(0, 0, 0, 1, 1, 0, 0,   1));
    apply_row("after2", v(0, 0, 0, 1, 1, 4, 1,   2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
